// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits in front of decode. It owns the program counter,
// issues one word request at a time to instruction memory over a
// req/gnt/rvalid handshake, and holds the returned word in an instruction
// register. Decode sees the register through a valid/ready handshake.
// Redirects from execute replace the PC and cause any response that is
// already in flight to be thrown away when it arrives.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-high
//   imem_req_out     fetch request to instruction memory
//   imem_addr_out    word-aligned fetch address (stable until granted)
//   imem_gnt_in      request accepted this cycle
//   imem_rvalid_in   read data valid this cycle
//   imem_rdata_in    read data
//   redirect_in      PC redirect strobe from execute
//   redirect_pc_in   redirect target (bits [1:0] are ignored)
//   instr_ready_in   decode accepts the held instruction
//   instr_valid_out  instruction register holds a valid instruction
//   instr_out        instruction register
//   pc_out           PC of instr_out
//   op_code_out      instr_out[6:0]
//   func3_out        instr_out[14:12]
//   func7_out        instr_out[31:25]
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_out,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic                  imem_gnt_in,
  input  logic                  imem_rvalid_in,
  input  logic [DATA_WIDTH-1:0] imem_rdata_in,
  input  logic                  redirect_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  input  logic                  instr_ready_in,
  output logic                  instr_valid_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [6:0]            op_code_out,
  output logic [2:0]            func3_out,
  output logic [6:0]            func7_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic                  drop_q, drop_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] target_s;

  // Redirect targets are always treated as word addresses.
  assign target_s = redirect_pc_in & ALIGN_MASK;

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    drop_d  = drop_q;
    valid_d = valid_q;

    case (state_q)
      S_FETCH: begin
        // A redirect cannot withdraw a request already on the bus: the
        // address stays put and the eventual response is marked stale.
        if (redirect_in) begin
          pc_d   = target_s;
          drop_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
        if (imem_gnt_in) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WAIT: begin
        if (imem_rvalid_in) begin
          if (drop_q || redirect_in) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
            if (redirect_in) begin
              pc_d = target_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            ir_d    = imem_rdata_in;
            ir_pc_d = addr_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_in) begin
          pc_d   = target_s;
          drop_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_HOLD: begin
        // Redirect wins over ready: the held instruction is abandoned,
        // not consumed.
        if (redirect_in) begin
          pc_d    = target_s;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (instr_ready_in) begin
          pc_d    = addr_q + PC_STEP;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d = S_FETCH;
        valid_d = 1'b0;
        drop_d  = 1'b0;
      end
    endcase

    // The request address is latched only when FETCH is entered, so it
    // stays stable for the whole life of the request.
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= {DATA_WIDTH{1'b0}};
      ir_pc_q <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

  // Request is suppressed while reset is held so nothing leaves the
  // block until the first cycle with rst low.
  assign imem_req_out    = (state_q == S_FETCH) && !rst;
  assign imem_addr_out   = addr_q;
  assign instr_valid_out = valid_q;
  assign instr_out       = ir_q;
  assign pc_out          = ir_pc_q;
  assign op_code_out     = ir_q[6:0];
  assign func3_out       = ir_q[14:12];
  assign func7_out       = ir_q[31:25];

endmodule
